// File: rtl/arith_ctrl_pkg.sv
// Shared encodings for the multi-cycle arithmetic machine control path.
package arith_ctrl_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;

    // Primary opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0e;

    // R-type function codes
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_XOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC2_REG  = 2'd0,
        SRC2_SEXT = 2'd1,
        SRC2_ZEXT = 2'd2
    } src2_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_e;

    // Decoded control bundle for one instruction
    typedef struct packed {
        logic      legal;
        logic      rd_src;
        src2_sel_e alu_src2;
        alu_op_e   alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_ILLEGAL = '{legal: 1'b0, rd_src: 1'b0,
                                       alu_src2: SRC2_REG, alu_op: ALU_NONE};

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [FUNCT_W-1:0] funct_of(input logic [INST_W-1:0] inst);
        return inst[5:0];
    endfunction

endpackage

// File: rtl/arith_ctrl_decode.sv
// Combinational opcode/funct decoder; illegal encodings yield all-zero controls.
module arith_ctrl_decode
    import arith_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic       rd_src,
    output logic [1:0] alu_src2,
    output logic [2:0] alu_op
);

    ctrl_t ctrl;

    // Map the instruction fields to the datapath control bundle
    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                ctrl.legal    = 1'b1;
                ctrl.rd_src   = 1'b0;
                ctrl.alu_src2 = SRC2_REG;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    default: ctrl = CTRL_ILLEGAL;
                endcase
            end
            OP_ADDI: ctrl = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_SEXT, alu_op: ALU_ADD};
            OP_ANDI: ctrl = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_AND};
            OP_ORI:  ctrl = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_OR};
            OP_XORI: ctrl = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_XOR};
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

    assign legal    = ctrl.legal;
    assign rd_src   = ctrl.rd_src;
    assign alu_src2 = ctrl.alu_src2;
    assign alu_op   = ctrl.alu_op;

endmodule

// File: rtl/arith_mc_sequencer.sv
// FETCH/DECODE/EXEC control sequencer with imem handshake, IR, exceptions and retire count.
module arith_mc_sequencer
    import arith_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      inst_in,
    output logic [31:0]      ir,
    output logic             pc_en,
    output logic             rf_wr_enable,
    output logic             rd_src,
    output logic [1:0]       alu_src2,
    output logic [2:0]       alu_op,
    output logic             except,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state, state_next;
    logic [31:0]       ir_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              except_next;
    logic [1:0]        cause_next;
    logic [CNT_W-1:0]  retired_next;
    logic              legal;

    // Control fields are decoded straight from the held instruction
    arith_ctrl_decode u_decode (
        .opcode   (opcode_of(ir)),
        .funct    (funct_of(ir)),
        .legal    (legal),
        .rd_src   (rd_src),
        .alu_src2 (alu_src2),
        .alu_op   (alu_op)
    );

    // State, IR, counters and state-derived enables, all reset synchronously
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_FETCH;
            ir           <= '0;
            wait_cnt     <= '0;
            except       <= 1'b0;
            cause        <= CAUSE_NONE;
            retired      <= '0;
            imem_req     <= 1'b1;
            pc_en        <= 1'b0;
            rf_wr_enable <= 1'b0;
        end else begin
            state        <= state_next;
            ir           <= ir_next;
            wait_cnt     <= wait_next;
            except       <= except_next;
            cause        <= cause_next;
            retired      <= retired_next;
            imem_req     <= (state_next == ST_FETCH);
            pc_en        <= (state_next == ST_EXEC);
            rf_wr_enable <= (state_next == ST_EXEC);
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes the fetch
    always_comb begin
        state_next   = state;
        ir_next      = ir;
        wait_next    = wait_cnt;
        except_next  = except;
        cause_next   = cause;
        retired_next = retired;
        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_next    = inst_in;
                    wait_next  = '0;
                    state_next = ST_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    except_next = 1'b1;
                    cause_next  = CAUSE_TIMEOUT;
                    state_next  = ST_HALT;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_next = ST_EXEC;
                end else begin
                    except_next = 1'b1;
                    cause_next  = CAUSE_ILLEGAL;
                    state_next  = ST_HALT;
                end
            end
            ST_EXEC: begin
                retired_next = retired + CNT_W'(1);
                state_next   = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

endmodule

// File: doc/arith_mc_sequencer.md
Name: arith_mc_sequencer

Overview:
Multi-cycle control sequencer for the arithmetic machine datapath (PC register, instruction memory, regfile, 32-bit ALU, sign/zero-extend mux). It replaces single-cycle control with a FETCH/DECODE/EXEC state machine. It runs a req/ack handshake to a variable-latency instruction memory, holds the instruction register (IR), and drives PC, regfile and ALU controls. It also detects illegal instructions and fetch timeouts, and counts retired instructions.

Parameters:
TIMEOUT, 16, max cycles FETCH waits for imem_ack before raising an exception (must be >= 1)
CNT_W, 32, width of the retired-instruction counter

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high; returns all state and outputs to reset values
imem_req  output  1  instruction fetch request
imem_ack  input  1  memory presents a valid instruction on inst_in this cycle
inst_in  input  32  instruction word from memory
ir  output  32  registered instruction; feeds the rs/rt/rd/imm16 fields of the datapath
pc_en  output  1  PC register write enable (PC <= PC+4)
rf_wr_enable  output  1  regfile write enable
rd_src  output  1  write-address mux select: 0 = rd, 1 = rt
alu_src2  output  2  ALU B mux select: 0 = B, 1 = sign-extended imm16, 2 = zero-extended imm16
alu_op  output  3  ALU operation code
except  output  1  sticky exception flag
cause  output  2  exception cause: 0 none, 1 illegal instruction, 2 fetch timeout
retired  output  CNT_W  number of instructions completed

Behaviour:
- Reset values: state=FETCH, ir=0, except=0, cause=0, retired=0, wait counter=0. Reset wins over every other event, including one arriving mid-handshake or in HALT.
- Moore outputs: pc_en, rf_wr_enable and imem_req depend on state only. rd_src, alu_src2 and alu_op are combinational from ir.
- FETCH: imem_req=1.
  - imem_ack=1: ir<=inst_in, wait counter clears, go to DECODE.
  - No ack: wait counter increments. When the counter reaches TIMEOUT-1 without an ack, set except=1, cause=2, go to HALT.
  - Ack and timeout in the same cycle: ack wins.
- DECODE: imem_req=0, no writes.
  - Legal ir: go to EXEC.
  - Illegal ir: except=1, cause=1, go to HALT. PC is not advanced.
- EXEC: rf_wr_enable=1 and pc_en=1 for exactly one cycle, retired<=retired+1 (wraps modulo 2^CNT_W), go to FETCH.
- HALT: all enables 0, imem_req=0. State, ir, cause and retired are held until reset.
- Throughput: minimum 3 cycles per instruction (ack in the first FETCH cycle). Each cycle of ack delay adds one cycle.
- imem_ack outside FETCH is ignored.
- Legal R-type (opcode 0x00), with rd_src=0 and alu_src2=0:
  - add 0x20 -> alu_op 2
  - sub 0x22 -> alu_op 3
  - and 0x24 -> alu_op 4
  - or 0x25 -> alu_op 5
  - nor 0x27 -> alu_op 6
  - xor 0x26 -> alu_op 7
  - Any other funct is illegal.
- Legal I-type, with rd_src=1:
  - addi 0x08 -> alu_src2=1, alu_op 2
  - andi 0x0c -> alu_src2=2, alu_op 4
  - ori 0x0d -> alu_src2=2, alu_op 5
  - xori 0x0e -> alu_src2=2, alu_op 7
  - Any other opcode is illegal.
- For an illegal ir, rd_src, alu_src2 and alu_op drive 0.

Decomposition:
- Package arith_ctrl_pkg holds:
  - opcode and funct constants
  - ALU op codes (ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7)
  - alu_src2 select codes
  - state encoding (FETCH, DECODE, EXEC, HALT)
  - cause codes
- One combinational sub-module, arith_ctrl_decode, maps opcode/funct to rd_src, alu_src2, alu_op and a legal flag. The sequencer instantiates it on ir.

Test Plan:
- Zero-wait add: reset, then ack on the first req with inst_in=0x00221820 (add $3,$1,$2) -> DECODE at cycle 2. At cycle 3: rf_wr_enable=1, pc_en=1, rd_src=0, alu_src2=0, alu_op=2. Then retired=1 and FETCH on cycle 4.
- Wait states: ack delayed 5 cycles on addi 0x20220005 -> imem_req high for 6 cycles and ir unchanged until the ack. EXEC shows alu_src2=1, rd_src=1, alu_op=2.
- Immediate and logic mix: stream ori 0x34220F0F, andi, xori, sub, nor, xor -> alu_op sequence 5,4,7,3,6,7 and alu_src2 sequence 2,2,2,0,0,0. After the stream, retired=6.
- Illegal instruction: opcode 0x23 (lw) -> except=1, cause=1 the cycle after DECODE. pc_en is never asserted, outputs freeze in HALT, and later acks are ignored.
- Timeout: TIMEOUT=16, ack never asserted -> except=1 and cause=2 after exactly 16 FETCH cycles. A separate run with the ack on the 16th cycle -> normal progress, no exception.
- Reset mid-operation: assert reset during EXEC and separately during HALT -> next cycle state=FETCH, except=0, cause=0, retired=0, ir=0, no write enables pulsed.
